// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned magnitude comparator: walks one compare cell from MSB to LSB,
// optionally stopping at the first differing bit, with valid/ready on both sides.
module serial_compare_ctrl #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1,
  parameter int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gr,
  output logic             le,
  output logic             eq,
  output logic [CW-1:0]    bits
);

  localparam int IW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             sgr_q, sgr_d;
  logic             gr_q, gr_d, le_q, le_d, eq_q, eq_d;
  logic [CW-1:0]    bits_q, bits_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic g_s, l_s, diff_s, finish_s;

  // Single compare cell on the current bit plus the stop condition.
  always_comb begin
    g_s      = ra_q[idx_q] & ~rb_q[idx_q];
    l_s      = ~ra_q[idx_q] & rb_q[idx_q];
    diff_s   = g_s | l_s;
    finish_s = ((EARLY_EXIT != 0) && diff_s) || (idx_q == {IW{1'b0}});
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    seen_d      = seen_q;
    sgr_d       = sgr_q;
    gr_d        = gr_q;
    le_d        = le_q;
    eq_d        = eq_q;
    bits_d      = bits_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ra_d       = a;
          rb_d       = b;
          idx_d      = IW'(WIDTH - 1);
          cnt_d      = {CW{1'b0}};
          seen_d     = 1'b0;
          sgr_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        // The first (MSB-most) difference is sticky; lower bits never override it.
        if (diff_s && !seen_q) begin
          seen_d = 1'b1;
          sgr_d  = g_s;
        end else begin
          seen_d = seen_q;
        end
        if (finish_s) begin
          gr_d        = seen_q ? sgr_q : g_s;
          le_d        = seen_q ? ~sgr_q : l_s;
          eq_d        = ~seen_q & ~diff_s;
          bits_d      = cnt_q + CW'(1);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any compare in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ra_q        <= {WIDTH{1'b0}};
      rb_q        <= {WIDTH{1'b0}};
      idx_q       <= {IW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      seen_q      <= 1'b0;
      sgr_q       <= 1'b0;
      gr_q        <= 1'b0;
      le_q        <= 1'b0;
      eq_q        <= 1'b0;
      bits_q      <= {CW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      sgr_q       <= sgr_d;
      gr_q        <= gr_d;
      le_q        <= le_d;
      eq_q        <= eq_d;
      bits_q      <= bits_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign gr        = gr_q;
  assign le        = le_q;
  assign eq        = eq_q;
  assign bits      = bits_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl: index 0 runs EARLY_EXIT=0, index 1 runs EARLY_EXIT=1.
module tb_serial_compare_ctrl;

  localparam int W  = 8;
  localparam int CB = 4;

  typedef struct {
    bit     g;
    bit     l;
    bit     e;
    int     bits;
    longint acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          iv[2], ir[2], ov[2], ordy[2], gr[2], le[2], eq[2];
  logic [W-1:0]  av[2], bv[2];
  logic [CB-1:0] bits[2];

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(0)) u_full (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .gr(gr[0]), .le(le[0]), .eq(eq[0]), .bits(bits[0]));

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1)) u_early (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .gr(gr[1]), .le(le[1]), .eq(eq[1]), .bits(bits[1]));

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  bit     rnd_rdy[2];
  bit     have[2];
  bit     post_hs[2];
  exp_t   cur[2];
  exp_t   q0[$];
  exp_t   q1[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned compare; bits = WIDTH minus position of highest differing bit.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input bit ee);
    exp_t r;
    int   d;
    d      = int'(x ^ y);
    r.g    = (x > y);
    r.l    = (x < y);
    r.e    = (x == y);
    r.acc  = 0;
    if (!ee || d == 0) r.bits = W;
    else r.bits = W - ($clog2(d + 1) - 1);
    return r;
  endfunction

  // Accept-edge sampler: pushes the expected result and the accept cycle.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (iv[i] && ir[i]) begin
          exp_t e;
          e     = model(av[i], bv[i], i == 1);
          e.acc = cyc;
          if (i == 0) q0.push_back(e);
          else q1.push_back(e);
        end
      end
    end
    cyc++;
  end

  // Monitor: pops on the first cycle of out_valid, then checks hold until handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (post_hs[i]) begin
          chk("ready_after_handshake", int'(ir[i]), 1);
          chk("valid_dropped_after_handshake", int'(ov[i]), 0);
          post_hs[i] = 1'b0;
        end
        if (ov[i]) begin
          if (!have[i]) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
              checks++;
              errors++;
              $display("FAIL unexpected_result dut=%0d actual=out_valid required=none", i);
            end else begin
              if (i == 0) cur[i] = q0.pop_front();
              else cur[i] = q1.pop_front();
              have[i] = 1'b1;
              chk("latency", int'(cyc - cur[i].acc - 1), cur[i].bits);
            end
          end
          if (have[i]) begin
            chk("gr", int'(gr[i]), int'(cur[i].g));
            chk("le", int'(le[i]), int'(cur[i].l));
            chk("eq", int'(eq[i]), int'(cur[i].e));
            chk("bits", int'(bits[i]), cur[i].bits);
            chk("onehot", int'(gr[i]) + int'(le[i]) + int'(eq[i]), 1);
            chk("busy_in_ready", int'(ir[i]), 0);
            if (ordy[i]) begin
              have[i]    = 1'b0;
              post_hs[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Random consumer back-pressure when enabled.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rnd_rdy[i]) ordy[i] = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    int t;
    t     = 0;
    iv[i] = 1'b1;
    av[i] = x;
    bv[i] = y;
    while (t < 300) begin
      @(negedge clk);
      if (ir[i]) begin
        @(posedge clk);
        #1;
        break;
      end
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut=%0d actual=not_accepted required=accepted", i);
    end
    iv[i] = 1'b0;
    av[i] = 8'($urandom);
    bv[i] = 8'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || have[0] || have[1]) && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=pending required=empty");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input int i);
    chk("rst_in_ready", int'(ir[i]), 1);
    chk("rst_out_valid", int'(ov[i]), 0);
    chk("rst_gr", int'(gr[i]), 0);
    chk("rst_le", int'(le[i]), 0);
    chk("rst_eq", int'(eq[i]), 0);
    chk("rst_bits", int'(bits[i]), 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; av[i] = '0; bv[i] = '0; ordy[i] = 1'b1;
      rnd_rdy[i] = 1'b0; have[i] = 1'b0; post_hs[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_values(0);
    check_reset_values(1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values(1);

    send(1, 8'hA5, 8'h25);
    send(1, 8'h3C, 8'h3D);
    send(1, 8'h77, 8'h77);
    send(0, 8'h80, 8'h7F);
    send(0, 8'hA5, 8'h25);
    send(0, 8'h3C, 8'h3D);
    wait_idle();

    // Back-pressure with a competing pair held on the input.
    ordy[1] = 1'b0;
    send(1, 8'h10, 8'h20);
    for (int t = 0; t < 50 && !ov[1]; t++) @(posedge clk);
    #1;
    iv[1] = 1'b1; av[1] = 8'hFF; bv[1] = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_in_ready_low", int'(ir[1]), 0);
    ordy[1] = 1'b1;
    send(1, 8'hFF, 8'h00);
    wait_idle();

    // Reset in the middle of a full-width compare.
    send(0, 8'h55, 8'hAA);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values(0);
    q0.delete(); q1.delete();
    have[0] = 1'b0; have[1] = 1'b0; post_hs[0] = 1'b0; post_hs[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      chk("no_valid_after_abort", int'(ov[0]), 0);
    end

    rnd_rdy[0] = 1'b1;
    rnd_rdy[1] = 1'b1;
    fork
      begin
        for (int n = 0; n < 3000; n++) begin
          logic [W-1:0] x, y;
          x = 8'($urandom);
          y = ($urandom_range(0, 7) == 0) ? x : 8'($urandom);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          send(0, x, y);
        end
      end
      begin
        for (int n = 0; n < 3000; n++) begin
          logic [W-1:0] x, y;
          x = 8'($urandom);
          y = ($urandom_range(0, 7) == 0) ? x : 8'($urandom);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          send(1, x, y);
        end
      end
    join
    @(posedge clk);
    #1;
    rnd_rdy[0] = 1'b0; rnd_rdy[1] = 1'b0;
    ordy[0] = 1'b1; ordy[1] = 1'b1;
    wait_idle();
    chk("scoreboard_empty", q0.size() + q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
